instr_encoder: RTL and testbench

//  Sequential program loader/encoder: accepts one decoded instruction per handshake (opcode + register

---
 rtl/isa_pkg.sv | 66 ++++++
 rtl/instr_field_packer.sv | 57 +++++
 rtl/instr_encoder.sv | 147 ++++++++++++++
 tb/tb_instr_encoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA definitions shared by the program loader/encoder
// Contents: opcode enum (14 mnemonics), format classes and classifier,
//           field bit positions of the 32-bit word, error codes, loader FSM states.
package isa_pkg;

  localparam int ISA_INSTR_W = 32;
  localparam int ISA_OP_W    = 5;
  localparam int ISA_REG_W   = 4;
  localparam int ISA_IMM_W   = ISA_INSTR_W - ISA_OP_W - 2 * ISA_REG_W;

  // Field LSB positions: op[31:27] ra[26:23] rb[22:19] rc[18:15] / imm[18:0]
  localparam int OP_LSB = ISA_INSTR_W - ISA_OP_W;
  localparam int RA_LSB = OP_LSB - ISA_REG_W;
  localparam int RB_LSB = RA_LSB - ISA_REG_W;
  localparam int RC_LSB = RB_LSB - ISA_REG_W;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_SLT  = 5'b00101,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_ADDI = 5'b10000,
    OP_ANDI = 5'b10001,
    OP_ORI  = 5'b10010,
    OP_LW   = 5'b10011,
    OP_SW   = 5'b10100,
    OP_LUI  = 5'b10101
  } opcode_e;

  typedef enum logic [1:0] {
    FMT_R       = 2'd0,
    FMT_B       = 2'd1,
    FMT_I       = 2'd2,
    FMT_ILLEGAL = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_IMM      = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic fmt_e op_format(input logic [ISA_OP_W-1:0] op);
    fmt_e f;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT:    f = FMT_R;
      OP_BEQ, OP_BNE:                                   f = FMT_B;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_LUI:   f = FMT_I;
      default:                                          f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational packer: decoded fields -> 32-bit instruction word
// Ports:
//   op, ra, rb, rc   opcode and register indices (rc used by R-type only)
//   imm              32-bit signed immediate (B/I-type only)
//   word             packed instruction word
//   illegal          opcode is not one of the 14 defined mnemonics
//   imm_fault        B/I immediate does not fit IMM_W signed bits
// Config: IMM_RANGE_CHECK_EN enables imm_fault; otherwise imm is truncated and imm_fault=0.
module instr_field_packer
  import isa_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 4
) (
  input  logic [4:0]         op,
  input  logic [REG_W-1:0]   ra,
  input  logic [REG_W-1:0]   rb,
  input  logic [REG_W-1:0]   rc,
  input  logic [31:0]        imm,
  output logic [INSTR_W-1:0] word,
  output logic               illegal,
  output logic               imm_fault
);

  localparam int IMM_W   = INSTR_W - 5 - 2 * REG_W;
  localparam int F_OP    = INSTR_W - 5;
  localparam int F_RA    = F_OP - REG_W;
  localparam int F_RB    = F_RA - REG_W;
  localparam int F_RC    = F_RB - REG_W;

  fmt_e fmt;

  always_comb begin
    fmt     = op_format(op);
    illegal = (fmt == FMT_ILLEGAL);
    word    = '0;
    word[F_OP +: 5]     = op;
    word[F_RA +: REG_W] = ra;
    word[F_RB +: REG_W] = rb;
    if (fmt == FMT_R)
      word[F_RC +: REG_W] = rc;
    else
      word[IMM_W-1:0] = imm[IMM_W-1:0];
  end

`ifdef IMM_RANGE_CHECK_EN
  // In range iff bits [31:IMM_W-1] are all copies of the field's sign bit.
  logic imm_fits;
  assign imm_fits  = (&imm[31:IMM_W-1]) | ~(|imm[31:IMM_W-1]);
  assign imm_fault = ((fmt == FMT_B) || (fmt == FMT_I)) && !imm_fits;
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:IMM_W];
  assign imm_fault     = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - sequential program loader: packs decoded instructions and writes them to instr. RAM
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, base_addr              begin a load at base_addr (IDLE only)
//   in_valid/in_ready             instruction handshake; in_op/in_ra/in_rb/in_rc/in_imm/in_last fields
//   mem_we, mem_addr, mem_wdata   one-cycle write strobe with registered address/word
//   busy, done                    load in progress / one-cycle completion pulse
//   err, err_code, count          sticky error + cause, words written in this load
// Config: IMM_RANGE_CHECK_EN makes out-of-range B/I immediates fault with err_code 11.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_op,
  input  logic [REG_W-1:0]   in_ra,
  input  logic [REG_W-1:0]   in_rb,
  input  logic [REG_W-1:0]   in_rc,
  input  logic [31:0]        in_imm,
  input  logic               in_last,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    count
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e             state;
  logic [ADDR_W-1:0]  addr;
  logic               addr_full;   // top address already written; further words overflow
  logic               last_q;

  logic [INSTR_W-1:0] pk_word;
  logic               pk_illegal;
  logic               pk_imm_fault;

  instr_field_packer #(
    .INSTR_W (INSTR_W),
    .REG_W   (REG_W)
  ) u_packer (
    .op        (in_op),
    .ra        (in_ra),
    .rb        (in_rb),
    .rc        (in_rc),
    .imm       (in_imm),
    .word      (pk_word),
    .illegal   (pk_illegal),
    .imm_fault (pk_imm_fault)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      addr_full <= 1'b0;
      last_q    <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            addr_full <= 1'b0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ACCEPT;
          end
        end

        S_ACCEPT: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            // Fault priority: illegal opcode, then overflow, then immediate range.
            if (pk_illegal || addr_full || pk_imm_fault) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
              if (pk_illegal)
                err_code <= ERR_ILLEGAL;
              else if (addr_full)
                err_code <= ERR_OVERFLOW;
              else
                err_code <= ERR_IMM;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= pk_word;
              last_q    <= in_last;
              state     <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          mem_we <= 1'b0;
          count  <= count + CNT_ONE;
          if (addr == ADDR_MAX)
            addr_full <= 1'b1;
          else
            addr <= addr + ADDR_ONE;
          if (last_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_ACCEPT;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a program-level reference model
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [3:0]  in_ra, in_rb, in_rc;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [8:0]  count;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_rc     (in_rc),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observed memory writes and done pulses
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  // Program under test
  int unsigned p_op[16], p_ra[16], p_rb[16], p_rc[16];
  logic [31:0] p_imm[16];
  int          p_n;
  logic [7:0]  p_base;

  // Expected results
  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_code, exp_count, exp_consumed;

  function automatic bit is_legal(int unsigned op);
    return (op <= 5) || (op == 8) || (op == 9) || (op >= 16 && op <= 21);
  endfunction

  // Walks the program as the loader would: each instruction either writes one word or stops the load.
  task automatic model();
    int a;
    bit full;
    int unsigned word;
    a = p_base;
    full = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_code = 0;
    exp_consumed = 0;
    for (int i = 0; i < p_n; i++) begin
      exp_consumed = i + 1;
      if (!is_legal(p_op[i])) begin exp_code = 1; break; end
      if (full) begin exp_code = 2; break; end
`ifdef IMM_RANGE_CHECK_EN
      if (p_op[i] > 5) begin
        int s;
        s = $signed(p_imm[i]);
        if (s < -262144 || s > 262143) begin exp_code = 3; break; end
      end
`endif
      word = p_op[i] * 134217728 + p_ra[i] * 8388608 + p_rb[i] * 524288;
      if (p_op[i] <= 5) word = word + p_rc[i] * 32768;
      else              word = word + (p_imm[i] % 524288);
      exp_addr_q.push_back(a[7:0]);
      exp_data_q.push_back(word);
      if (a == 255) full = 1;
      a = a + 1;
    end
    exp_count = exp_addr_q.size();
  endtask

  task automatic set_i(input int i, input int unsigned op, input int unsigned ra,
                       input int unsigned rb, input int unsigned rc, input logic [31:0] imm);
    p_op[i] = op; p_ra[i] = ra; p_rb[i] = rb; p_rc[i] = rc; p_imm[i] = imm;
  endtask

  task automatic run_program(input string tag, input bit start_dup);
    int w;
    model();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    @(negedge clk);
    base_addr = p_base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    if (start_dup) begin
      // A second start while busy must not move the load
      base_addr = p_base + 8'h40;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < exp_consumed; i++) begin
      in_op = p_op[i][4:0]; in_ra = p_ra[i][3:0]; in_rb = p_rb[i][3:0];
      in_rc = p_rc[i][3:0]; in_imm = p_imm[i];
      in_last = (i == p_n - 1);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      if (!in_ready) begin
        chk({tag, "_ready_timeout"}, in_ready, 1);
        in_valid = 1'b0;
        break;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_op = 5'($urandom); in_imm = $urandom;
    end
    w = 0;
    while (!done && w < 20) begin @(negedge clk); w++; end
    chk({tag, "_done_seen"}, done, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_err"}, err, (exp_code != 0));
    chk({tag, "_err_code"}, err_code, exp_code);
    chk({tag, "_count"}, count, exp_count);
    chk({tag, "_nwrites"}, wr_addr_q.size(), exp_addr_q.size());
    if (wr_addr_q.size() == exp_addr_q.size()) begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
        chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  int unsigned legal_ops[14] = '{0, 1, 2, 3, 4, 5, 8, 9, 16, 17, 18, 19, 20, 21};
  int unsigned bad_ops[18]   = '{6, 7, 10, 11, 12, 13, 14, 15, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31};

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_op = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_imm = '0; in_last = 1'b0;
    done_cnt = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // 1: single R-type
    p_base = 8'h10; p_n = 1;
    set_i(0, 0, 1, 2, 3, 32'h0);
    run_program("t1_add", 0);

    // 2: ADDI imm=-1 then LW, with a stray start while busy
    p_base = 8'h20; p_n = 2;
    set_i(0, 16, 4, 5, 9, 32'hFFFF_FFFF);
    set_i(1, 19, 1, 2, 0, 32'd8);
    run_program("t2_addi_lw", 1);

    // 3: illegal opcode
    p_base = 8'h30; p_n = 1;
    set_i(0, 15, 1, 1, 1, 32'h0);
    run_program("t3_illegal", 0);

    // 4: overflow past the top address
    p_base = 8'hFF; p_n = 2;
    set_i(0, 1, 2, 3, 4, 32'h0);
    set_i(1, 2, 5, 6, 7, 32'h0);
    run_program("t4_overflow", 0);

    // 5: immediate out of 19-bit signed range
    p_base = 8'h40; p_n = 1;
    set_i(0, 16, 3, 7, 0, 32'd300000);
    run_program("t5_imm", 0);

    // Priority: illegal beats overflow; overflow beats immediate range
    p_base = 8'hFF; p_n = 2;
    set_i(0, 8, 1, 2, 0, 32'h0003_FFFF);
    set_i(1, 30, 0, 0, 0, 32'h0);
    run_program("prio_ill_ovf", 0);
    p_base = 8'hFF; p_n = 2;
    set_i(0, 9, 1, 2, 0, 32'hFFFC_0000);
    set_i(1, 17, 0, 0, 0, 32'd300000);
    run_program("prio_ovf_imm", 0);
    p_base = 8'h50; p_n = 1;
    set_i(0, 23, 0, 0, 0, 32'd300000);
    run_program("prio_ill_imm", 0);

    // 6: reset during WRITE drops the pending write
    @(negedge clk);
    base_addr = 8'h60; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_op = 5'd0; in_ra = 4'd7; in_rb = 4'd8; in_rc = 4'd9; in_imm = '0; in_last = 1'b1;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("t6_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t6_we_before_rst", mem_we, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("t6_in_rst");
    @(negedge clk);
    rst = 1'b0;
    p_base = 8'h61; p_n = 3;
    set_i(0, 20, 1, 2, 0, 32'h0000_1234);
    set_i(1, 5, 3, 4, 5, 32'h0);
    set_i(2, 21, 6, 7, 0, 32'hFFFF_FF00);
    run_program("t6_after_rst", 0);

    // Randomized programs
    for (int k = 0; k < 40; k++) begin
      p_n = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) p_base = 8'hFC + 8'($urandom_range(0, 3));
      else                           p_base = 8'($urandom);
      for (int i = 0; i < p_n; i++) begin
        int unsigned op;
        logic [31:0] imm;
        if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 17)];
        else                           op = legal_ops[$urandom_range(0, 13)];
        if ($urandom_range(0, 4) == 0) imm = $urandom;
        else imm = 32'($signed($urandom_range(0, 524287)) - 262144);
        set_i(i, op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), imm);
      end
      run_program($sformatf("rnd%0d", k), k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
